rmii_rx_deframer: RTL and testbench
===================================

# rmii_rx_deframer

Receive-path deframer for the RMII PHY side, running directly on the 50 MHz RMII reference clock. It decodes CRS_DV/RXD dibits at 10 Mb/s or 100 Mb/s, strips preamble/SFD, and assembles LSB-first bytes. It resolves the RMII CRS_DV end-of-frame toggling and optionally checks the Ethernet FCS, marking the last byte of each frame with EOF and an error flag. It sits between the RMII pins and the MAC receive logic, replacing the nibble-level MII receive conversion with a byte stream.

## Interface
- MIN_PREAMBLE, default 8: minimum count of consecutive `01` dibits required before the SFD-completing `11` dibit (range 2..28).
- CHECK_FCS, default 1: 1 = CRC-32 residue check at frame end; 0 = FCS bytes are passed through and never flagged.
- phy_rmii_ref_clk  in  1  50 MHz RMII reference clock; the only clock in the block.
- rstn_async  in  1  asynchronous, active-low reset.
- mode_speed  in  1  1 = 100M (every cycle is a dibit), 0 = 10M (each dibit is held 10 cycles). Sampled only while IDLE.
- phy_rmii_crsdv  in  1  RMII CRS_DV.
- phy_rmii_rxer  in  1  RMII RX_ER.
- phy_rmii_rxd  in  2  RMII receive dibit.
- out_valid  out  1  one-cycle strobe: out_data is valid.
- out_data  out  8  received byte, first dibit in bits [1:0].
- out_sof  out  1  qualifies out_valid: first byte after the SFD.
- out_eof  out  1  qualifies out_valid: last byte of the frame.
- out_err  out  1  qualifies out_eof: frame is bad.

## Operation
- Sample strobe:
  - In 100M mode, every cycle is a sample point.
  - In 10M mode, a mod-10 counter is cleared on the first cycle crsdv rises while in IDLE, and the sample point is at count 5. The counter then free-runs until the block returns to IDLE.
- State machine (transitions happen only on sample points):
  - IDLE -> PREAMBLE on crsdv=1.
  - PREAMBLE:
    - An `01` dibit increments the preamble counter, saturating at 31.
    - An `11` dibit with counter >= MIN_PREAMBLE -> DATA, with dibit phase p=0, byte dibit index 0, and CRC preset to 0xFFFFFFFF.
    - Any other dibit, or `11` with counter < MIN_PREAMBLE -> DISCARD.
    - crsdv=0 -> IDLE.
  - DATA: dibits are accepted per the CRS_DV rule below, and a byte completes every 4 accepted dibits.
  - DISCARD: wait until crsdv=0 holds at two consecutive sample points, then -> IDLE. Nothing is emitted.
- CRS_DV rule in DATA (p toggles on every sample):
  - p=0, crsdv=1: accept.
  - p=0, crsdv=0: hold the dibit as pending.
  - p=1 after a pending dibit:
    - crsdv=1 (carrier toggle): accept both dibits.
    - crsdv=0: frame end; drop the pending dibit.
  - p=1, crsdv=0 with p=0 high: accept; carrier is dropping.
- Byte emission is delayed by one byte so EOF marks the last byte:
  - A completed byte is stored in a holding register.
  - The previously held byte is emitted when a new byte completes.
  - At frame end, the held byte is emitted with out_eof=1. If no byte was ever completed, nothing is emitted.
- out_err at EOF is the OR of:
  - RX_ER=1 at any DATA sample.
  - Accepted dibit count not a multiple of 4 at frame end; the partial byte is dropped.
  - CHECK_FCS=1 and CRC residue != 0xC704DD7B.
  - Fewer than 1 complete byte when CHECK_FCS=0, or fewer than 4 complete bytes when CHECK_FCS=1.
- CRC-32 (poly 0x04C11DB7, reflected) is updated per accepted byte in arrival order.
- After frame end -> IDLE. A new preamble may follow from the next sample point.

## Timing
- All outputs reset to 0. State resets to IDLE and every counter to 0.
- Reset deassertion is synchronised to the clock inside the block; the first active edge is the second clock after release.
- out_valid for byte N rises 1 cycle after the sample point completing byte N+1.
- The EOF byte is emitted 1 cycle after the frame-end sample point; out_sof/out_eof/out_err are valid only in that cycle.
- Single-byte frame: out_sof and out_eof are both 1 on the same strobe.
- Minimum out_valid spacing is 4 cycles at 100M and 40 cycles at 10M. There is no backpressure.
- Reset mid-frame: outputs clear immediately. No EOF is generated for the aborted frame.
- A mode_speed change outside IDLE is ignored until the next IDLE.

## Test plan
- 100M, CHECK_FCS=0:
  - Stimulus: crsdv high; 14 dibits `01`, then `11`; data nibbles 0,1,2..9 (dibits LSB first); crsdv low for 2 cycles.
  - Required: bytes 0x10, 0x32, 0x54, 0x76, 0x98 with SOF on 0x10, EOF on 0x98, err=0.
- 100M, CHECK_FCS=1:
  - Stimulus: 60-byte payload + correct FCS.
  - Required: 64 strobes, EOF err=0.
  - Same frame with one flipped data bit -> EOF err=1.
- CRS_DV toggle:
  - Stimulus: after the last byte, crsdv pattern 0,1,0,1 carrying one extra byte 0xA5, then 0,0.
  - Required: 0xA5 emitted as EOF byte, err=0 (CHECK_FCS=0).
- 10M mode:
  - Stimulus: same stream as the first test, each dibit held 10 cycles.
  - Required: identical byte sequence, strobes 40 cycles apart.
- Error and abort cases:
  - Short preamble (3 dibits of `01`, then `11`) -> no output.
  - RX_ER pulsed on one data dibit -> EOF err=1.
  - 6 data dibits -> one byte with EOF err=1.
- Reset asserted mid-frame:
  - Required: all outputs 0 within the same cycle.
  - The next clean frame is received correctly.

Source files
------------

// File: rtl/rmii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : rmii_rx_deframer
// Description : RMII receive deframer on the 50 MHz reference clock. Samples
//               CRS_DV/RXD dibits at 100M (every cycle) or 10M (one sample per
//               10 cycles), strips preamble/SFD, assembles LSB-first bytes,
//               resolves CRS_DV end-of-frame toggling, optionally checks the
//               FCS, and emits a byte stream with SOF/EOF/error qualifiers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   phy_rmii_ref_clk  in   50 MHz RMII reference clock (only clock)
//   rstn_async        in   asynchronous active-low reset
//   mode_speed        in   1 = 100M, 0 = 10M (taken only while idle)
//   phy_rmii_crsdv    in   RMII CRS_DV
//   phy_rmii_rxer     in   RMII RX_ER
//   phy_rmii_rxd      in   RMII receive dibit
//   out_valid         out  one-cycle strobe, out_data valid
//   out_data          out  received byte, first dibit in [1:0]
//   out_sof           out  first byte of frame (with out_valid)
//   out_eof           out  last byte of frame (with out_valid)
//   out_err           out  frame is bad (with out_eof)
// ============================================================================
module rmii_rx_deframer #(
    parameter int MIN_PREAMBLE = 8,
    parameter int CHECK_FCS    = 1
) (
    input  logic       phy_rmii_ref_clk,
    input  logic       rstn_async,
    input  logic       mode_speed,
    input  logic       phy_rmii_crsdv,
    input  logic       phy_rmii_rxer,
    input  logic [1:0] phy_rmii_rxd,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_err
);

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    // Residue of a good frame in this (non-reflected, LSB-first fed) register.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [4:0]  MIN_PRE_C   = 5'(MIN_PREAMBLE);
    localparam logic [2:0]  MIN_BYTES   = (CHECK_FCS != 0) ? 3'd4 : 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DISC = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Reset: asserted asynchronously, released synchronously.
    // ------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge phy_rmii_ref_clk or negedge rstn_async) begin
        if (!rstn_async) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        speed_q, speed_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        crsdv_prev_q;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic        phase_q, phase_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_dib_q, pend_dib_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  sr_q, sr_d;
    logic [31:0] crc_q, crc_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        rxer_seen_q, rxer_seen_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        hold_first_q, hold_first_d;
    logic        disc_low_q, disc_low_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eof_q, out_eof_d;
    logic        out_err_q, out_err_d;

    // ------------------------------------------------------------------------
    // Sample strobe. The speed is frozen outside IDLE. At 10M the mod-10
    // counter is realigned on a CRS_DV rising edge seen in IDLE, that cycle
    // being count 0, so the sample lands mid-dibit at count 5.
    // ------------------------------------------------------------------------
    logic idle;
    logic speed;
    logic rise_clr;
    logic sample;

    assign idle     = (state_q == ST_IDLE);
    assign speed    = idle ? mode_speed : speed_q;
    assign rise_clr = idle && phy_rmii_crsdv && !crsdv_prev_q;
    assign sample   = speed ? 1'b1 : ((cnt_q == 4'd5) && !rise_clr);
    assign speed_d  = speed;
    assign cnt_d    = rise_clr ? 4'd1 : ((cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    logic [1:0] n_acc;
    logic [1:0] dib0;
    logic [1:0] dib1;
    logic       frame_end;
    logic [7:0] asm_byte;
    logic [2:0] idx_sum;
    logic       crc_bad;

    assign crc_bad = (CHECK_FCS != 0) && (crc_q != CRC_RESIDUE);

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        phase_d      = phase_q;
        pend_d       = pend_q;
        pend_dib_d   = pend_dib_q;
        idx_d        = idx_q;
        sr_d         = sr_q;
        crc_d        = crc_q;
        nbytes_d     = nbytes_q;
        rxer_seen_d  = rxer_seen_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        hold_first_d = hold_first_q;
        disc_low_d   = disc_low_q;
        out_valid_d  = 1'b0;
        out_data_d   = 8'h00;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        out_err_d    = 1'b0;
        n_acc        = 2'd0;
        dib0         = phy_rmii_rxd;
        dib1         = phy_rmii_rxd;
        frame_end    = 1'b0;
        asm_byte     = sr_q;
        idx_sum      = 3'd0;

        if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    if (phy_rmii_crsdv) begin
                        state_d   = ST_PRE;
                        pre_cnt_d = (phy_rmii_rxd == 2'b01) ? 5'd1 : 5'd0;
                    end
                end
                ST_PRE: begin
                    if (!phy_rmii_crsdv) begin
                        state_d = ST_IDLE;
                    end else if (phy_rmii_rxd == 2'b01) begin
                        if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
                    end else if ((phy_rmii_rxd == 2'b11) && (pre_cnt_q >= MIN_PRE_C)) begin
                        state_d     = ST_DATA;
                        phase_d     = 1'b0;
                        pend_d      = 1'b0;
                        idx_d       = 2'd0;
                        sr_d        = 8'h00;
                        crc_d       = 32'hFFFF_FFFF;
                        nbytes_d    = 3'd0;
                        rxer_seen_d = 1'b0;
                        hold_vld_d  = 1'b0;
                    end else begin
                        state_d    = ST_DISC;
                        disc_low_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    phase_d     = ~phase_q;
                    rxer_seen_d = rxer_seen_q | phy_rmii_rxer;
                    if (!phase_q) begin
                        // CRS_DV low on an even sample may be a carrier toggle;
                        // the odd sample decides whether the dibit is kept.
                        if (phy_rmii_crsdv) begin
                            n_acc = 2'd1;
                        end else begin
                            pend_d     = 1'b1;
                            pend_dib_d = phy_rmii_rxd;
                        end
                    end else if (pend_q) begin
                        pend_d = 1'b0;
                        if (phy_rmii_crsdv) begin
                            n_acc = 2'd2;
                            dib0  = pend_dib_q;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end else begin
                        n_acc = 2'd1;
                    end
                end
                default: begin
                    if (!phy_rmii_crsdv) begin
                        if (disc_low_q) state_d = ST_IDLE;
                        disc_low_d = 1'b1;
                    end else begin
                        disc_low_d = 1'b0;
                    end
                end
            endcase
        end

        // Byte assembly. Two dibits are only accepted on an odd sample with the
        // pending dibit at an even index, so they never straddle a byte.
        if (n_acc != 2'd0) begin
            asm_byte[{idx_q, 1'b0} +: 2] = dib0;
            if (n_acc == 2'd2) asm_byte[{idx_q + 2'd1, 1'b0} +: 2] = dib1;
            idx_sum = {1'b0, idx_q} + {1'b0, n_acc};
            idx_d   = idx_sum[1:0];
            sr_d    = asm_byte;
            if (idx_sum[2]) begin
                crc_d = crc_byte(crc_q, asm_byte);
                if (nbytes_q != 3'd4) nbytes_d = nbytes_q + 3'd1;
                // One-byte delay so the last byte can carry EOF.
                if (hold_vld_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hold_q;
                    out_sof_d   = hold_first_q;
                end
                hold_d       = asm_byte;
                hold_vld_d   = 1'b1;
                hold_first_d = !hold_vld_q;
            end
        end

        if (frame_end) begin
            state_d    = ST_IDLE;
            hold_vld_d = 1'b0;
            if (hold_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_q;
                out_sof_d   = hold_first_q;
                out_eof_d   = 1'b1;
                out_err_d   = rxer_seen_d | (idx_q != 2'd0) | crc_bad |
                              (nbytes_q < MIN_BYTES);
            end
        end
    end

    always_ff @(posedge phy_rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            speed_q      <= 1'b0;
            cnt_q        <= 4'd0;
            crsdv_prev_q <= 1'b0;
            pre_cnt_q    <= 5'd0;
            phase_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_dib_q   <= 2'd0;
            idx_q        <= 2'd0;
            sr_q         <= 8'h00;
            crc_q        <= 32'd0;
            nbytes_q     <= 3'd0;
            rxer_seen_q  <= 1'b0;
            hold_q       <= 8'h00;
            hold_vld_q   <= 1'b0;
            hold_first_q <= 1'b0;
            disc_low_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            speed_q      <= speed_d;
            cnt_q        <= cnt_d;
            crsdv_prev_q <= phy_rmii_crsdv;
            pre_cnt_q    <= pre_cnt_d;
            phase_q      <= phase_d;
            pend_q       <= pend_d;
            pend_dib_q   <= pend_dib_d;
            idx_q        <= idx_d;
            sr_q         <= sr_d;
            crc_q        <= crc_d;
            nbytes_q     <= nbytes_d;
            rxer_seen_q  <= rxer_seen_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            hold_first_q <= hold_first_d;
            disc_low_q   <= disc_low_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rmii_rx_deframer
// Description : Directed self-checking bench. Two instances share the RMII
//               inputs: dut0 with FCS checking off, dut1 with it on. A monitor
//               records every output strobe; each test task then compares the
//               recorded strobes against hand-derived expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rmii_rx_deframer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rstn;
    logic       mode_speed;
    logic       crsdv;
    logic       rxer;
    logic [1:0] rxd;

    logic       v0, s0, e0, r0;
    logic [7:0] d0;
    logic       v1, s1, e1, r1;
    logic [7:0] d1;

    rmii_rx_deframer #(.MIN_PREAMBLE(8), .CHECK_FCS(0)) dut0 (
        .phy_rmii_ref_clk (clk),
        .rstn_async       (rstn),
        .mode_speed       (mode_speed),
        .phy_rmii_crsdv   (crsdv),
        .phy_rmii_rxer    (rxer),
        .phy_rmii_rxd     (rxd),
        .out_valid        (v0),
        .out_data         (d0),
        .out_sof          (s0),
        .out_eof          (e0),
        .out_err          (r0)
    );

    rmii_rx_deframer #(.MIN_PREAMBLE(8), .CHECK_FCS(1)) dut1 (
        .phy_rmii_ref_clk (clk),
        .rstn_async       (rstn),
        .mode_speed       (mode_speed),
        .phy_rmii_crsdv   (crsdv),
        .phy_rmii_rxer    (rxer),
        .phy_rmii_rxd     (rxd),
        .out_valid        (v1),
        .out_data         (d1),
        .out_sof          (s1),
        .out_eof          (e1),
        .out_err          (r1)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        err;
    } rec_t;

    rec_t        q0[$];
    rec_t        q1[$];
    logic [7:0]  frm[$];
    logic [31:0] cyc = 32'd0;
    int          total = 0;
    int          bad = 0;
    int          hold = 1;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk) begin
        if (v0) q0.push_back(rec_t'({cyc, d0, s0, e0, r0}));
        if (v1) q1.push_back(rec_t'({cyc, d1, s1, e1, r1}));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic c, input logic [1:0] d, input logic e);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            crsdv = c; rxd = d; rxer = e;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            crsdv = 1'b0; rxd = 2'b00; rxer = 1'b0;
        end
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] er);
        for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2], er[i]);
    endtask

    task automatic send_end();
        drive(1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
    endtask

    task automatic send_frame(input int npre);
        send_pre(npre);
        foreach (frm[i]) send_byte(frm[i], 4'b0000);
        send_end();
        settle(12);
    endtask

    task automatic load_basic();
        // nibbles 0..9 packed low nibble first
        frm = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; mode_speed = 1'b1; crsdv = 1'b0; rxer = 1'b0; rxd = 2'b00;
        repeat (4) @(negedge clk);
        total++;
        if ({v0, d0, s0, e0, r0} !== 12'h000) begin
            bad++; $display("FAIL reset_out0 got=%0h exp=0", {v0, d0, s0, e0, r0});
        end
        total++;
        if ({v1, d1, s1, e1, r1} !== 12'h000) begin
            bad++; $display("FAIL reset_out1 got=%0h exp=0", {v1, d1, s1, e1, r1});
        end
        rstn = 1'b1;
        settle(8);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++; $display("FAIL reset_idle_strobes got=%0d exp=0", q0.size() + q1.size());
        end
    endtask

    task automatic test_basic();
        q0.delete(); q1.delete();
        load_basic();
        send_frame(14);
        total++;
        if (q0.size() != 5) begin
            bad++; $display("FAIL basic_count got=%0d exp=5", q0.size());
        end
        for (int i = 0; i < 5 && i < q0.size(); i++) begin
            total++;
            if ({q0[i].data, q0[i].sof, q0[i].eof} !== {frm[i], i == 0, i == 4}) begin
                bad++; $display("FAIL basic_byte%0d got=%0h/%0b%0b exp=%0h/%0b%0b", i,
                                q0[i].data, q0[i].sof, q0[i].eof, frm[i], i == 0, i == 4);
            end
        end
        for (int i = 1; i < 4 && i < q0.size(); i++) begin
            total++;
            if (q0[i].cyc - q0[i-1].cyc !== 32'd4) begin
                bad++; $display("FAIL basic_spacing%0d got=%0d exp=4", i, q0[i].cyc - q0[i-1].cyc);
            end
        end
        if (q0.size() > 0) begin
            total++;
            if (q0[q0.size()-1].err !== 1'b0) begin
                bad++; $display("FAIL basic_err got=1 exp=0");
            end
        end
        // the FCS-checking instance sees 5 bytes with no valid FCS
        total++;
        if (q1.size() != 5 || q1[q1.size()-1].err !== 1'b1) begin
            bad++; $display("FAIL basic_fcs_inst got_n=%0d exp_n=5 exp_err=1", q1.size());
        end
    endtask

    task automatic test_fcs();
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i * 37 + 5));
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        frm.push_back(c[7:0]); frm.push_back(c[15:8]);
        frm.push_back(c[23:16]); frm.push_back(c[31:24]);

        q0.delete(); q1.delete();
        send_frame(8);  // exactly the minimum preamble
        total++;
        if (q1.size() != 64) begin
            bad++; $display("FAIL fcs_count got=%0d exp=64", q1.size());
        end
        if (q1.size() == 64) begin
            total++;
            if ({q1[0].sof, q1[0].data, q1[63].eof, q1[63].err, q1[63].data} !==
                {1'b1, frm[0], 1'b1, 1'b0, frm[63]}) begin
                bad++; $display("FAIL fcs_good got=%0b/%0h/%0b/%0b/%0h exp=1/%0h/1/0/%0h",
                                q1[0].sof, q1[0].data, q1[63].eof, q1[63].err, q1[63].data,
                                frm[0], frm[63]);
            end
        end
        total++;
        if (q0.size() != 64 || q0[q0.size()-1].err !== 1'b0) begin
            bad++; $display("FAIL fcs_passthru got_n=%0d exp_n=64 exp_err=0", q0.size());
        end

        frm[10] = frm[10] ^ 8'h04;
        q0.delete(); q1.delete();
        send_frame(8);
        total++;
        if (q1.size() != 64 || q1[q1.size()-1].err !== 1'b1) begin
            bad++; $display("FAIL fcs_bad got_n=%0d exp_n=64 exp_err=1", q1.size());
        end
        total++;
        if (q0.size() != 64 || q0[q0.size()-1].err !== 1'b0) begin
            bad++; $display("FAIL fcs_bad_nocheck got_n=%0d exp_n=64 exp_err=0", q0.size());
        end
    endtask

    task automatic test_toggle();
        logic [7:0] exp6 [6];
        exp6 = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hA5};
        q0.delete(); q1.delete();
        load_basic();
        send_pre(14);
        foreach (frm[i]) send_byte(frm[i], 4'b0000);
        // 0xA5 = dibits 01,01,10,10 carried under a toggling CRS_DV
        drive(1'b0, 2'b01, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b0, 2'b10, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        send_end();
        settle(12);
        total++;
        if (q0.size() != 6) begin
            bad++; $display("FAIL toggle_count got=%0d exp=6", q0.size());
        end
        for (int i = 0; i < 6 && i < q0.size(); i++) begin
            total++;
            if (q0[i].data !== exp6[i]) begin
                bad++; $display("FAIL toggle_byte%0d got=%0h exp=%0h", i, q0[i].data, exp6[i]);
            end
        end
        if (q0.size() == 6) begin
            total++;
            if ({q0[5].eof, q0[5].err, q0[4].eof} !== 3'b100) begin
                bad++; $display("FAIL toggle_eof got=%0b exp=100", {q0[5].eof, q0[5].err, q0[4].eof});
            end
        end
    endtask

    task automatic test_10m();
        q0.delete(); q1.delete();
        mode_speed = 1'b0;
        hold = 10;
        load_basic();
        send_frame(14);
        hold = 1;
        mode_speed = 1'b1;
        settle(4);
        total++;
        if (q0.size() != 5) begin
            bad++; $display("FAIL m10_count got=%0d exp=5", q0.size());
        end
        for (int i = 0; i < 5 && i < q0.size(); i++) begin
            total++;
            if ({q0[i].data, q0[i].sof, q0[i].eof} !== {frm[i], i == 0, i == 4}) begin
                bad++; $display("FAIL m10_byte%0d got=%0h exp=%0h", i, q0[i].data, frm[i]);
            end
        end
        for (int i = 1; i < 4 && i < q0.size(); i++) begin
            total++;
            if (q0[i].cyc - q0[i-1].cyc !== 32'd40) begin
                bad++; $display("FAIL m10_spacing%0d got=%0d exp=40", i, q0[i].cyc - q0[i-1].cyc);
            end
        end
    endtask

    task automatic test_errors();
        // short preambles: 3 and MIN-1
        q0.delete(); q1.delete();
        load_basic();
        send_frame(3);
        send_frame(7);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++; $display("FAIL short_pre got=%0d exp=0", q0.size() + q1.size());
        end

        // RX_ER on one data dibit
        q0.delete(); q1.delete();
        send_pre(14);
        foreach (frm[i]) send_byte(frm[i], (i == 2) ? 4'b0100 : 4'b0000);
        send_end();
        settle(12);
        total++;
        if (q0.size() != 5 || q0[q0.size()-1].err !== 1'b1 || q0[q0.size()-1].eof !== 1'b1) begin
            bad++; $display("FAIL rxer got_n=%0d exp_n=5 exp_err=1", q0.size());
        end

        // six data dibits: one byte, partial tail dropped and flagged
        q0.delete(); q1.delete();
        send_pre(14);
        send_byte(8'h3C, 4'b0000);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        send_end();
        settle(12);
        total++;
        if (q0.size() != 1 || {q0[0].data, q0[0].sof, q0[0].eof, q0[0].err} !== {8'h3C, 3'b111}) begin
            bad++; $display("FAIL partial got_n=%0d exp=3C/111", q0.size());
        end

        // clean single-byte frame
        q0.delete(); q1.delete();
        frm = '{8'hE7};
        send_frame(14);
        total++;
        if (q0.size() != 1 || {q0[0].data, q0[0].sof, q0[0].eof, q0[0].err} !== {8'hE7, 3'b110}) begin
            bad++; $display("FAIL single got_n=%0d exp=E7/110", q0.size());
        end
        total++;
        if (q1.size() != 1 || q1[0].err !== 1'b1) begin
            bad++; $display("FAIL single_fcs got_n=%0d exp_n=1 exp_err=1", q1.size());
        end
    endtask

    task automatic test_reset_mid();
        q0.delete(); q1.delete();
        send_pre(14);
        send_byte(8'h11, 4'b0000);
        send_byte(8'h22, 4'b0000);
        @(posedge clk);
        #2;
        total++;
        if ({v0, d0} !== {1'b1, 8'h11}) begin
            bad++; $display("FAIL rstmid_pre got=%0b/%0h exp=1/11", v0, d0);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({v0, d0, s0, e0, r0, v1, d1, s1, e1, r1} !== 24'h0) begin
            bad++; $display("FAIL rstmid_clear got=%0h exp=0", {v0, d0, s0, e0, r0, v1, d1, s1, e1, r1});
        end
        settle(3);
        rstn = 1'b1;
        settle(8);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++; $display("FAIL rstmid_noeof got=%0d exp=0", q0.size() + q1.size());
        end
        load_basic();
        send_frame(14);
        total++;
        if (q0.size() != 5) begin
            bad++; $display("FAIL rstmid_count got=%0d exp=5", q0.size());
        end
        for (int i = 0; i < 5 && i < q0.size(); i++) begin
            total++;
            if ({q0[i].data, q0[i].sof, q0[i].eof, q0[i].err} !== {frm[i], i == 0, i == 4, 1'b0}) begin
                bad++; $display("FAIL rstmid_byte%0d got=%0h exp=%0h", i, q0[i].data, frm[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fcs();
        test_toggle();
        test_10m();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
